// File: rtl/ros2_eth_pkg.sv
// ============================================================================
// Module      : ros2_eth_pkg
// Description : Shared definitions for the multi-channel IPv4 TX adapter:
//               header size and field offsets, FSM state encoding and the
//               parsed-header record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ros2_eth_pkg;

    localparam int IP_HDR_SIZE            = 20;
    localparam int IP_HDR_OFFSET_TOS      = 1;
    localparam int IP_HDR_OFFSET_LEN_HI   = 2;
    localparam int IP_HDR_OFFSET_LEN_LO   = 3;
    localparam int IP_HDR_OFFSET_TTL      = 8;
    localparam int IP_HDR_OFFSET_PROTO    = 9;
    localparam int IP_HDR_OFFSET_CSUM     = 10;
    localparam int IP_HDR_OFFSET_SRC      = 12;
    localparam int IP_HDR_OFFSET_DST      = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_READ_HDR   = 3'd1;
    localparam logic [2:0] ST_TX_HDR     = 3'd2;
    localparam logic [2:0] ST_TX_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DROP       = 3'd4;

    typedef struct packed {
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] length;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [31:0] source_ip;
        logic [31:0] dest_ip;
    } ip_hdr_t;

endpackage

`default_nettype wire

// File: rtl/ros2_rr_arbiter.sv
// ============================================================================
// Module      : ros2_rr_arbiter
// Description : Round-robin arbiter. Picks the first requesting channel after
//               the stored pointer (cyclic) and moves the pointer onto the
//               winner when the grant is taken.
// Ports       : i_clk, i_rst (async, active-high), i_req (request vector),
//               i_advance (grant consumed), o_grant (one-hot), o_grant_idx,
//               o_grant_valid (any request present)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ros2_rr_arbiter #(
    parameter int N_CH = 2,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_req,
    input  logic            i_advance,
    output logic [N_CH-1:0] o_grant,
    output logic [CH_W-1:0] o_grant_idx,
    output logic            o_grant_valid
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_idx;

    // Scan from the furthest candidate to the nearest so the channel closest
    // after the pointer is the one left standing.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = CH_W'((int'(r_ptr) + k) % N_CH);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_grant_valid  = 1'b1;
            end
        end
    end

    // Pointer starts on the last channel so channel 0 wins first after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= CH_W'(N_CH - 1);
        end else if (i_advance) begin
            r_ptr <= o_grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ros2_eth_tx_mux_adapter.sv
// ============================================================================
// Module      : ros2_eth_tx_mux_adapter
// Description : Multi-channel IPv4 TX adapter. Round-robin selects one byte
//               FIFO per packet, parses its 20-byte IPv4 header into the IP TX
//               header handshake and streams the payload over AXI-Stream.
//               Packets with total length < 20 or > MAX_LEN are dropped with
//               an o_err_len pulse.
// Option      : ROS2_TX_CSUM_CHECK_EN - verify the header checksum and drop
//               packets whose checksum does not fold to 16'hFFFF.
// Ports       : i_clk/i_rst (async, active-high), i_enable, per-channel FIFO
//               read side (i_din_*, o_din_rd_en), header handshake
//               (o_tx_hdr_valid/i_tx_hdr_ready + fields), payload AXI-Stream,
//               status (o_cur_ch, o_busy, o_err_len)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ros2_eth_tx_mux_adapter
    import ros2_eth_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int MAX_LEN = 1500,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [8*N_CH-1:0] i_din_data,
    input  logic [N_CH-1:0]   i_din_empty_n,
    output logic [N_CH-1:0]   o_din_rd_en,
    output logic              o_tx_hdr_valid,
    input  logic              i_tx_hdr_ready,
    output logic [5:0]        o_tx_ip_dscp,
    output logic [1:0]        o_tx_ip_ecn,
    output logic [15:0]       o_tx_ip_length,
    output logic [7:0]        o_tx_ip_ttl,
    output logic [7:0]        o_tx_ip_protocol,
    output logic [31:0]       o_tx_ip_source_ip,
    output logic [31:0]       o_tx_ip_dest_ip,
    output logic              o_tx_payload_tvalid,
    input  logic              i_tx_payload_tready,
    output logic [7:0]        o_tx_payload_tdata,
    output logic              o_tx_payload_tlast,
    output logic              o_tx_payload_tkeep,
    output logic              o_tx_payload_tstrb,
    output logic [CH_W-1:0]   o_cur_ch,
    output logic              o_busy,
    output logic              o_err_len
);

    localparam logic [15:0] c_hdr_len = 16'(IP_HDR_SIZE);
    localparam logic [15:0] c_max_len = 16'(MAX_LEN);

    logic [2:0]      r_state;
    logic [CH_W-1:0] r_cur_ch;
    logic [N_CH-1:0] r_grant_oh;
    ip_hdr_t         r_hdr;
    logic [4:0]      r_byte_cnt;
    logic [15:0]     r_len;
    logic [15:0]     r_cnt;
    logic [15:0]     r_rem;
    logic            r_err_len;

    logic [N_CH-1:0] w_grant;
    logic [CH_W-1:0] w_grant_idx;
    logic            w_grant_valid;
    logic            w_start;
    logic [7:0]      w_sel_data;
    logic            w_sel_empty_n;
    logic            w_rd_gate;
    logic            w_pop;
    logic            w_tlast;
    logic            w_csum_bad;

    assign w_start = (r_state == ST_IDLE) && i_enable && w_grant_valid;

    ros2_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_din_empty_n),
        .i_advance     (w_start),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Mux the granted channel using the registered one-hot grant.
    always_comb begin
        w_sel_data    = 8'h00;
        w_sel_empty_n = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_grant_oh[c]) begin
                w_sel_data    = i_din_data[8*c +: 8];
                w_sel_empty_n = i_din_empty_n[c];
            end
        end
    end

    always_comb begin
        w_rd_gate = 1'b0;
        case (r_state)
            ST_READ_HDR, ST_DROP: w_rd_gate = 1'b1;
            ST_TX_PAYLOAD:        w_rd_gate = i_tx_payload_tready;
            default:              w_rd_gate = 1'b0;
        endcase
    end

    assign w_pop       = w_sel_empty_n & w_rd_gate;
    assign o_din_rd_en = r_grant_oh & i_din_empty_n & {N_CH{w_rd_gate}};
    assign w_tlast     = (r_state == ST_TX_PAYLOAD) && ((r_cnt + 16'd1) == r_len);

`ifdef ROS2_TX_CSUM_CHECK_EN
    // Ones-complement accumulation: the 17th bit carries into the next add,
    // and the final result is folded twice so 0x1FFFF-style sums settle.
    logic [16:0] r_csum;
    logic [7:0]  r_csum_hi;
    logic [16:0] w_csum_add;
    logic [16:0] w_fold;

    always_comb begin
        w_csum_add = {1'b0, r_csum[15:0]} + {16'd0, r_csum[16]} + {1'b0, r_csum_hi, w_sel_data};
        w_fold     = {1'b0, w_csum_add[15:0]} + {16'd0, w_csum_add[16]};
        w_csum_bad = (w_fold[15:0] + {15'd0, w_fold[16]}) != 16'hFFFF;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csum    <= '0;
            r_csum_hi <= '0;
        end else if (r_state == ST_IDLE) begin
            r_csum    <= '0;
        end else if ((r_state == ST_READ_HDR) && w_pop) begin
            if (!r_byte_cnt[0]) begin
                r_csum_hi <= w_sel_data;
            end else begin
                r_csum    <= w_csum_add;
            end
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cur_ch   <= '0;
            r_grant_oh <= '0;
            r_hdr      <= '0;
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_err_len  <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cur_ch   <= w_grant_idx;
                        r_grant_oh <= w_grant;
                        r_byte_cnt <= '0;
                        r_state    <= ST_READ_HDR;
                    end
                end
                ST_READ_HDR: begin
                    if (w_pop) begin
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                        case (r_byte_cnt)
                            5'(IP_HDR_OFFSET_TOS):    {r_hdr.dscp, r_hdr.ecn} <= w_sel_data;
                            5'(IP_HDR_OFFSET_LEN_HI): r_hdr.length[15:8] <= w_sel_data;
                            5'(IP_HDR_OFFSET_LEN_LO): r_hdr.length[7:0]  <= w_sel_data;
                            5'(IP_HDR_OFFSET_TTL):    r_hdr.ttl          <= w_sel_data;
                            5'(IP_HDR_OFFSET_PROTO):  r_hdr.protocol     <= w_sel_data;
                            default: ;
                        endcase
                        // Addresses arrive big-endian, so shift in from the LSB.
                        if ((r_byte_cnt >= 5'(IP_HDR_OFFSET_SRC)) && (r_byte_cnt < 5'(IP_HDR_OFFSET_SRC + 4)))
                            r_hdr.source_ip <= {r_hdr.source_ip[23:0], w_sel_data};
                        if (r_byte_cnt >= 5'(IP_HDR_OFFSET_DST))
                            r_hdr.dest_ip <= {r_hdr.dest_ip[23:0], w_sel_data};
                        // Length bytes were captured long before the last byte.
                        if (r_byte_cnt == 5'(IP_HDR_SIZE - 1)) begin
                            if (r_hdr.length < c_hdr_len) begin
                                r_err_len <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else if ((r_hdr.length > c_max_len) || w_csum_bad) begin
                                r_err_len <= 1'b1;
                                if (r_hdr.length == c_hdr_len) begin
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_rem   <= r_hdr.length - c_hdr_len;
                                    r_state <= ST_DROP;
                                end
                            end else begin
                                r_state <= ST_TX_HDR;
                            end
                        end
                    end
                end
                ST_TX_HDR: begin
                    if (i_tx_hdr_ready) begin
                        if (r_hdr.length == c_hdr_len) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_len   <= r_hdr.length - c_hdr_len;
                            r_cnt   <= '0;
                            r_state <= ST_TX_PAYLOAD;
                        end
                    end
                end
                ST_TX_PAYLOAD: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_tlast) r_state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_pop) begin
                        r_rem <= r_rem - 16'd1;
                        if (r_rem == 16'd1) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_hdr_valid      = (r_state == ST_TX_HDR);
    assign o_tx_ip_dscp        = r_hdr.dscp;
    assign o_tx_ip_ecn         = r_hdr.ecn;
    assign o_tx_ip_length      = r_hdr.length;
    assign o_tx_ip_ttl         = r_hdr.ttl;
    assign o_tx_ip_protocol    = r_hdr.protocol;
    assign o_tx_ip_source_ip   = r_hdr.source_ip;
    assign o_tx_ip_dest_ip     = r_hdr.dest_ip;
    assign o_tx_payload_tvalid = (r_state == ST_TX_PAYLOAD) && w_sel_empty_n;
    assign o_tx_payload_tdata  = (r_state == ST_TX_PAYLOAD) ? w_sel_data : 8'h00;
    assign o_tx_payload_tlast  = w_tlast;
    assign o_tx_payload_tkeep  = 1'b1;
    assign o_tx_payload_tstrb  = 1'b1;
    assign o_cur_ch            = r_cur_ch;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_err_len           = r_err_len;

endmodule

`default_nettype wire
